// File: rtl/pwm_mod_pkg.sv
// Shared helpers for the gated PWM generator.
// Derives the counter width from the period so that the top module stays parameter-driven.
package pwm_mod_pkg;

  // Width of the phase counter. A period of 1 still needs one bit.
  function automatic int cnt_width(input int freq);
    return (freq <= 1) ? 1 : $clog2(freq);
  endfunction

endpackage

// File: rtl/pwm_mod.sv
// Gated PWM generator: while din is high, dout carries DIVIDER_DTY high cycles per
// DIVIDER_FREQ-cycle period; each enable restarts the phase at 0.
module pwm_mod
  import pwm_mod_pkg::*;
#(
  parameter int DIVIDER_FREQ = 10,
  parameter int DIVIDER_DTY  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW  = cnt_width(DIVIDER_FREQ);
  localparam int CWP = CW + 1;
  // A high time longer than the period behaves like a full period.
  localparam int DTY_SAT = (DIVIDER_DTY > DIVIDER_FREQ) ? DIVIDER_FREQ : DIVIDER_DTY;
  localparam logic [CW:0] FREQ_M1 = CWP'((DIVIDER_FREQ > 0) ? DIVIDER_FREQ - 1 : 0);
  localparam logic [CW:0] DTY_C   = CWP'((DTY_SAT > 0) ? DTY_SAT : 0);

  if (DIVIDER_FREQ < 1) begin : g_bad_freq
    $error("pwm_mod: DIVIDER_FREQ must be >= 1");
  end

  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          w_wrap;
  logic          w_high;

  assign w_wrap = ({1'b0, r_cnt} == FREQ_M1);
  assign w_high = ({1'b0, r_cnt} < DTY_C);

  always_ff @(posedge clk) begin
    if (rst || !din) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else begin
      r_dout <= w_high;
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_pwm_mod.sv
// Scoreboard bench for pwm_mod: the default configuration plus DTY=0, DTY=FREQ and FREQ=1.
`timescale 1ns/100ps
module tb_pwm_mod;

  typedef struct {
    logic e_main;
    logic e_d0;
    logic e_d10;
    logic e_f1;
    bit   win;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout_main, dout_d0, dout_d10, dout_f1;

  int   total = 0;
  int   bad = 0;
  int   rise_cnt = 0;
  logic prev_main = 1'b0;
  int   ph = 0;
  exp_t q[$];

  // Hand-written steady-state waveform for FREQ=10, DTY=3, indexed by phase since enable.
  localparam logic [9:0] PAT = 10'b1110000000;

  always #1 clk = ~clk;

  pwm_mod #(.DIVIDER_FREQ(10), .DIVIDER_DTY(3))  dut     (.clk(clk), .rst(rst), .din(din), .dout(dout_main));
  pwm_mod #(.DIVIDER_FREQ(10), .DIVIDER_DTY(0))  dut_d0  (.clk(clk), .rst(rst), .din(din), .dout(dout_d0));
  pwm_mod #(.DIVIDER_FREQ(10), .DIVIDER_DTY(10)) dut_d10 (.clk(clk), .rst(rst), .din(din), .dout(dout_d10));
  pwm_mod #(.DIVIDER_FREQ(1),  .DIVIDER_DTY(1))  dut_f1  (.clk(clk), .rst(rst), .din(din), .dout(dout_f1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the output expected after the next edge.
  task automatic step(input logic r, input logic d, input bit win);
    exp_t e;
    @(negedge clk);
    rst = r;
    din = d;
    if (r || !d) begin
      e.e_main = 1'b0;
      ph = 0;
    end else begin
      e.e_main = PAT[9 - ph];
      ph = (ph + 1) % 10;
    end
    e.e_d0  = 1'b0;
    e.e_d10 = !r && d;
    e.e_f1  = !r && d;
    e.win   = win;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #0.5;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dout_main", 32'(dout_main), 32'(e.e_main));
        check("dout_dty0", 32'(dout_d0), 32'(e.e_d0));
        check("dout_dty10", 32'(dout_d10), 32'(e.e_d10));
        check("dout_freq1", 32'(dout_f1), 32'(e.e_f1));
        if (e.win && dout_main && !prev_main) rise_cnt++;
      end
      prev_main = dout_main;
    end
  end

  initial begin : stimulus
    // Reset held with din high: everything stays low.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #0.6;
    check("cnt_after_rst", 32'(dut.r_cnt), 32'd0);

    // 100 enabled cycles: repeating 3-high/7-low, exactly 10 rising edges.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #0.6;
    check("rise_count_100", 32'(rise_cnt), 32'd10);

    // Drop enable one cycle into the high phase, then hold off for a while.
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);

    // Re-enable: phase restarts, first pulse full width.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);

    // Reset pulse mid-operation, then a fresh sequence.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

    // Short enable toggles exercise the registered-din paths.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #0.6;
    end
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
